// File: rtl/seg7_scan_if.sv
// Write bus from the memory-mapped LED register into the seven-segment scanner.
interface seg7_scan_if;
  localparam int unsigned DATA_W = 32;

  logic              wr_en;
  logic              ctrl_en;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_en, output ctrl_en, output wr_data);
  modport slave  (input  wr_en, input  ctrl_en, input  wr_data);
endinterface

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment driver with a frame-boundary double buffer
// for the shown value and an unshadowed digit/dp mask control register.
module seg7_scan #(
  parameter int unsigned SCAN_DIV = 20000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  seg7_scan_if.slave  bus,
  output logic [7:0]  led_en,
  output logic        led_ca,
  output logic        led_cb,
  output logic        led_cc,
  output logic        led_cd,
  output logic        led_ce,
  output logic        led_cf,
  output logic        led_cg,
  output logic        led_dp,
  output logic        frame_done
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned DIGITS  = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned MASK_W  = 8;
  localparam int unsigned CNT_W   = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'b111_1111;

  // Active-low {ca..cg} hex font.
  function automatic logic [SEG_W-1:0] hex_font(input logic [3:0] nib);
    logic [SEG_W-1:0] seg;
    seg = SEG_OFF;
    case (nib)
      4'h0: seg = 7'b000_0001;
      4'h1: seg = 7'b100_1111;
      4'h2: seg = 7'b001_0010;
      4'h3: seg = 7'b000_0110;
      4'h4: seg = 7'b100_1100;
      4'h5: seg = 7'b010_0100;
      4'h6: seg = 7'b010_0000;
      4'h7: seg = 7'b000_1111;
      4'h8: seg = 7'b000_0000;
      4'h9: seg = 7'b000_0100;
      4'hA: seg = 7'b000_1000;
      4'hB: seg = 7'b110_0000;
      4'hC: seg = 7'b011_0001;
      4'hD: seg = 7'b100_0010;
      4'hE: seg = 7'b011_0000;
      4'hF: seg = 7'b011_1000;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] pending_q;
  logic [DATA_W-1:0] display_q;
  logic [MASK_W-1:0] digit_mask_q;
  logic [MASK_W-1:0] dp_mask_q;
  logic              wrap_q;

  logic [7:0]        led_en_q;
  logic [SEG_W-1:0]  seg_q;
  logic              dp_q;
  logic              frame_done_q;

  logic              cnt_last_c;
  logic              wrap_c;
  logic [DATA_W-1:0] upper_c;
  logic [3:0]        nib_c;
  logic              blank_c;
  logic [7:0]        led_en_c;
  logic [SEG_W-1:0]  seg_c;
  logic              dp_c;

  // Scan position and frame-boundary detection.
  always_comb begin
    cnt_last_c = (cnt_q == CNT_MAX);
    wrap_c     = cnt_last_c && (idx_q == IDX_LAST);
  end

  // Current-digit decode; upper_c holds nibbles idx..7, so zero means a leading zero.
  always_comb begin
    upper_c  = display_q >> {idx_q, 2'b00};
    nib_c    = upper_c[3:0];
    blank_c  = !digit_mask_q[idx_q] ||
               (BLANK_LZ && (idx_q != '0) && (upper_c == '0));
    led_en_c = 8'hFF;
    seg_c    = SEG_OFF;
    dp_c     = 1'b1;
    if (!blank_c) begin
      led_en_c = ~(8'd1 << idx_q);
      seg_c    = hex_font(nib_c);
      dp_c     = ~dp_mask_q[idx_q];
    end
  end

  // Scan counters, write registers and the frame-boundary load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pending_q    <= '0;
      display_q    <= '0;
      digit_mask_q <= 8'hFF;
      dp_mask_q    <= 8'h00;
      wrap_q       <= 1'b0;
    end else begin
      cnt_q  <= cnt_last_c ? '0 : cnt_q + CNT_W'(1);
      wrap_q <= wrap_c;
      if (cnt_last_c) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      if (bus.wr_en) begin
        pending_q <= bus.wr_data;
      end
      if (bus.ctrl_en) begin
        {dp_mask_q, digit_mask_q} <= bus.wr_data[15:0];
      end
      // A write landing on the wrap edge goes straight to the display.
      if (wrap_c) begin
        display_q <= bus.wr_en ? bus.wr_data : pending_q;
      end
    end
  end

  // Output register; frame_done lines up with the first output cycle of digit 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_en_q     <= 8'hFF;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      led_en_q     <= led_en_c;
      seg_q        <= seg_c;
      dp_q         <= dp_c;
      frame_done_q <= wrap_q;
    end
  end

  assign led_en     = led_en_q;
  assign led_ca     = seg_q[6];
  assign led_cb     = seg_q[5];
  assign led_cc     = seg_q[4];
  assign led_cd     = seg_q[3];
  assign led_ce     = seg_q[2];
  assign led_cf     = seg_q[1];
  assign led_cg     = seg_q[0];
  assign led_dp     = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: two instances (leading-zero blanking on and off) driven by the
// same write bus and compared every cycle against a frame/digit reference model.
module tb_seg7_scan;

  localparam int unsigned SD    = 4;
  localparam int unsigned FRAME = 8 * SD;
  localparam logic [6:0] FONT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  localparam logic [16:0] RESET_OUT = {8'hFF, 7'h7F, 1'b1, 1'b0};

  logic clk;
  logic rst_n;
  seg7_scan_if bus ();

  logic [7:0] en_a, en_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, fd_a, fd_b;

  seg7_scan #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .led_en(en_a), .led_ca(seg_a[6]), .led_cb(seg_a[5]), .led_cc(seg_a[4]),
    .led_cd(seg_a[3]), .led_ce(seg_a[2]), .led_cf(seg_a[1]), .led_cg(seg_a[0]),
    .led_dp(dp_a), .frame_done(fd_a)
  );

  seg7_scan #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut_all (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .led_en(en_b), .led_ca(seg_b[6]), .led_cb(seg_b[5]), .led_cc(seg_b[4]),
    .led_cd(seg_b[3]), .led_ce(seg_b[2]), .led_cf(seg_b[1]), .led_cg(seg_b[0]),
    .led_dp(dp_b), .frame_done(fd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks;
  int unsigned errors;

  // Reference state: cycles since reset, pending/display values, masks.
  int unsigned k;
  logic [31:0] m_pend, m_disp;
  logic [7:0]  m_mask, m_dpm;
  logic        fd_arm;
  logic [16:0] exp_a, exp_b;

  // Expected {led_en, segs, dp, frame_done} for a digit of a shown value.
  function automatic logic [16:0] expect_out(input logic [2:0] dig, input logic [31:0] disp,
                                             input logic [7:0] mask, input logic [7:0] dpm,
                                             input bit blz, input logic fd);
    logic [3:0] nib [8];
    bit all_zero;
    for (int j = 0; j < 8; j++) nib[j] = 4'(disp >> (4 * j));
    all_zero = 1'b1;
    for (int j = 0; j < 8; j++)
      if (j >= int'(dig) && nib[j] != 4'h0) all_zero = 1'b0;
    if (!mask[dig] || (blz && dig != 3'd0 && all_zero))
      return {8'hFF, 7'h7F, 1'b1, fd};
    return {8'hFF ^ (8'd1 << dig), FONT[nib[dig]], ~dpm[dig], fd};
  endfunction

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge: drive inputs, advance the model, then compare both instances.
  task automatic tick(input logic r, input logic w, input logic c, input logic [31:0] d);
    logic [2:0] dig;
    bit wrapnow;
    rst_n = r;
    bus.wr_en = w;
    bus.ctrl_en = c;
    bus.wr_data = d;
    @(posedge clk);
    if (!r) begin
      k = 0; m_pend = '0; m_disp = '0; m_mask = 8'hFF; m_dpm = 8'h00; fd_arm = 1'b0;
      exp_a = RESET_OUT;
      exp_b = RESET_OUT;
    end else begin
      dig = 3'((k / SD) % 8);
      wrapnow = (k % FRAME) == FRAME - 1;
      exp_a = expect_out(dig, m_disp, m_mask, m_dpm, 1'b1, fd_arm);
      exp_b = expect_out(dig, m_disp, m_mask, m_dpm, 1'b0, fd_arm);
      fd_arm = wrapnow;
      if (w) m_pend = d;
      if (c) {m_dpm, m_mask} = d[15:0];
      if (wrapnow) m_disp = m_pend;
      k++;
    end
    #1;
    check("dut_lz", {en_a, seg_a, dp_a, fd_a}, exp_a);
    check("dut_all", {en_b, seg_b, dp_b, fd_b}, exp_b);
  endtask

  task automatic run(input int n);
    repeat (n) tick(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  // Idle until the next edge would be at frame phase p.
  task automatic to_phase(input int unsigned p);
    repeat (FRAME) if ((k % FRAME) != p) tick(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  logic [31:0] rd;
  logic        rw, rc, rr;
  int          fd_count;

  initial begin
    checks = 0;
    errors = 0;
    k = 0;

    repeat (3) tick(1'b0, 1'b0, 1'b0, 32'h0);
    check("reset_outputs", {en_a, seg_a, dp_a, fd_a}, RESET_OUT);

    fd_count = 0;
    repeat (70) begin
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      if (fd_a) fd_count++;
    end
    check("frame_done_count", 17'(fd_count), 17'd2);

    to_phase(10);
    tick(1'b1, 1'b1, 1'b0, 32'h1234_5678);
    run(70);
    to_phase(0);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    check("digit0_eight", {en_a, seg_a, 2'b00}, {8'hFE, 7'b0000000, 2'b00});
    to_phase(28);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    check("digit7_one", {en_a, seg_a, 2'b00}, {8'h7F, 7'b1001111, 2'b00});

    tick(1'b1, 1'b1, 1'b0, 32'h0000_00A0);
    run(70);

    tick(1'b1, 1'b0, 1'b1, 32'h0000_01F0);
    run(40);
    tick(1'b1, 1'b0, 1'b1, 32'h0000_03FF);
    run(40);
    tick(1'b1, 1'b0, 1'b1, 32'h0000_00FF);

    to_phase(10);
    tick(1'b1, 1'b1, 1'b0, 32'hCAFE_0042);
    run(10);
    to_phase(31);
    tick(1'b1, 1'b1, 1'b0, 32'h00BE_EF07);
    run(40);

    to_phase(5);
    tick(1'b1, 1'b1, 1'b1, 32'h9876_F0FF);
    run(70);

    to_phase(20);
    tick(1'b1, 1'b1, 1'b0, 32'h5555_5555);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    run(70);

    repeat (700) begin
      rr = ($urandom_range(0, 199) != 0);
      rw = ($urandom_range(0, 9) == 0);
      rc = ($urandom_range(0, 29) == 0);
      rd = $urandom >> $urandom_range(0, 31);
      if (rc && $urandom_range(0, 1) == 1) rd[7:0] = 8'hFF;
      tick(rr, rw, rc, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
